// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC sequencer with direct-mapped BTB prediction, stall gating and mispredict flush.
module fetch_sequencer #(
    parameter int          BTB_ENTRIES  = 4,
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        mispredict,
    input  logic [15:0] pc_redirect,
    input  logic        btb_wr_en,
    input  logic        btb_wr_taken,
    input  logic [15:0] btb_wr_pc,
    input  logic [15:0] btb_wr_target,
    output logic [15:0] PC_ctrl,
    output logic        en_ctrl,
    output logic        pred_taken,
    output logic        flush,
    output logic [1:0]  state
);
    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
    state_t st, st_nx;
    logic [15:0] pc_next, pc_nx;
    logic [CW-1:0] flush_cnt, cnt_nx;
    logic [BTB_ENTRIES-1:0] valid;
    logic [15:0] tag [BTB_ENTRIES];
    logic [15:0] tgt [BTB_ENTRIES];
    logic [IW-1:0] idx, widx;
    logic hit;
    assign idx        = pc_next[IW-1:0];
    assign widx       = btb_wr_pc[IW-1:0];
    assign hit        = valid[idx] && tag[idx] == pc_next;
    assign PC_ctrl    = pc_next;
    assign pred_taken = hit;
    assign en_ctrl    = st == RUN && !stall_in && !mispredict;
    assign flush      = st == FLUSH;
    assign state      = st;
    always_comb begin
        st_nx  = st;
        pc_nx  = pc_next;
        cnt_nx = flush_cnt;
        if (mispredict) begin
            st_nx  = FLUSH;
            pc_nx  = pc_redirect + 16'd1;
            cnt_nx = CW'(FLUSH_CYCLES - 1);
        end else if (st == IDLE) begin
            st_nx = RUN;
        end else if (st == RUN) begin
            pc_nx = en_ctrl ? (hit ? tgt[idx] : pc_next + 16'd1) : pc_next;
        end else if (st == FLUSH) begin
            st_nx  = flush_cnt == '0 ? RUN : FLUSH;
            cnt_nx = flush_cnt == '0 ? flush_cnt : flush_cnt - CW'(1);
        end else begin
            st_nx = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            pc_next   <= RESET_PC;
            flush_cnt <= '0;
        end else begin
            st        <= st_nx;
            pc_next   <= pc_nx;
            flush_cnt <= cnt_nx;
        end
    end
    // Only valid bits need reset; tag/target are qualified by valid.
    always_ff @(posedge clk) begin
        if (rst) valid <= '0;
        else if (btb_wr_en) valid[widx] <= btb_wr_taken;
    end
    always_ff @(posedge clk) begin
        if (!rst && btb_wr_en && btb_wr_taken) begin
            tag[widx] <= btb_wr_pc;
            tgt[widx] <= btb_wr_target;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of sequencing, stalls, BTB prediction, mispredict flush and reset.
module tb_fetch_sequencer;
    logic        clk = 0, rst = 1, stall_in = 0, mispredict = 0;
    logic [15:0] pc_redirect = 0;
    logic        btb_wr_en = 0, btb_wr_taken = 0;
    logic [15:0] btb_wr_pc = 0, btb_wr_target = 0;
    logic [15:0] PC_ctrl;
    logic        en_ctrl, pred_taken, flush;
    logic [1:0]  state;
    int nchk = 0, nerr = 0;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .mispredict(mispredict),
        .pc_redirect(pc_redirect), .btb_wr_en(btb_wr_en), .btb_wr_taken(btb_wr_taken),
        .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target), .PC_ctrl(PC_ctrl),
        .en_ctrl(en_ctrl), .pred_taken(pred_taken), .flush(flush), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic see(input string tag, input logic [15:0] pc, input logic en, input logic fl, input logic pt);
        chk({tag, ".pc"}, PC_ctrl, pc);
        chk({tag, ".en"}, 16'(en_ctrl), 16'(en));
        chk({tag, ".flush"}, 16'(flush), 16'(fl));
        chk({tag, ".pred"}, 16'(pred_taken), 16'(pt));
    endtask

    task automatic mp(input logic [15:0] r);
        mispredict = 1;
        pc_redirect = r;
        #1;
        chk("mp.en", 16'(en_ctrl), 16'd0);
        tick();
        mispredict = 0;
    endtask

    task automatic btbw(input logic [15:0] pc, input logic [15:0] t, input logic taken);
        btb_wr_en = 1;
        btb_wr_pc = pc;
        btb_wr_target = t;
        btb_wr_taken = taken;
        tick();
        btb_wr_en = 0;
    endtask

    initial begin
        tick();
        tick();
        rst = 0;
        see("rst", 16'h0000, 0, 0, 0);
        chk("rst.state", 16'(state), 16'd0);
        tick();
        chk("run.state", 16'(state), 16'd1);
        see("seq0", 16'h0000, 1, 0, 0);
        tick(); see("seq1", 16'h0001, 1, 0, 0);
        tick(); see("seq2", 16'h0002, 1, 0, 0);
        tick(); see("seq3", 16'h0003, 1, 0, 0);
        tick(); tick();
        stall_in = 1;
        #1;
        see("stall1", 16'h0005, 0, 0, 0);
        tick(); see("stall2", 16'h0005, 0, 0, 0);
        tick(); see("stall3", 16'h0005, 0, 0, 0);
        tick();
        stall_in = 0;
        #1;
        see("unstall", 16'h0005, 1, 0, 0);
        tick(); see("after_stall", 16'h0006, 1, 0, 0);
        // BTB entry 4 -> 0x20, then restart fetch from 0 via redirect to 0xFFFF
        btbw(16'h0004, 16'h0020, 1);
        mp(16'hFFFF);
        see("fl1", 16'h0000, 0, 1, 0);
        chk("fl1.state", 16'(state), 16'd2);
        tick(); see("fl2", 16'h0000, 0, 1, 0);
        tick(); see("p0", 16'h0000, 1, 0, 0);
        tick(); see("p1", 16'h0001, 1, 0, 0);
        tick(); tick(); see("p3", 16'h0003, 1, 0, 0);
        tick(); see("p4", 16'h0004, 1, 0, 1);
        tick(); see("p20", 16'h0020, 1, 0, 0);
        tick(); see("p21", 16'h0021, 1, 0, 0);
        // mispredict beats stall
        stall_in = 1;
        mp(16'h0100);
        stall_in = 0;
        see("mpA1", 16'h0101, 0, 1, 0);
        tick(); see("mpA2", 16'h0101, 0, 1, 0);
        tick(); see("mpA3", 16'h0101, 1, 0, 0);
        // second mispredict during first flush cycle restarts the window
        mp(16'h0100);
        see("mpB1", 16'h0101, 0, 1, 0);
        mp(16'h0200);
        see("mpB2", 16'h0201, 0, 1, 0);
        tick(); see("mpB3", 16'h0201, 0, 1, 0);
        tick(); see("mpB4", 16'h0201, 1, 0, 0);
        // wrap
        mp(16'hFFFE);
        tick(); tick(); see("wrapF", 16'hFFFF, 1, 0, 0);
        tick(); see("wrap0", 16'h0000, 1, 0, 0);
        // alias: 8 displaces 4 at index 0
        btbw(16'h0008, 16'h0030, 1);
        mp(16'h0003);
        tick(); tick(); see("al4", 16'h0004, 1, 0, 0);
        tick(); see("al5", 16'h0005, 1, 0, 0);
        mp(16'h0007);
        tick(); tick(); see("al8", 16'h0008, 1, 0, 1);
        tick(); see("al30", 16'h0030, 1, 0, 0);
        btbw(16'h0008, 16'h0000, 0);
        mp(16'h0007);
        tick(); tick(); see("inv8", 16'h0008, 1, 0, 0);
        tick(); see("inv9", 16'h0009, 1, 0, 0);
        // reset mid-flush must also clear BTB entry for RESET_PC
        btbw(16'h0000, 16'h0040, 1);
        mp(16'h0500);
        chk("mf.state", 16'(state), 16'd2);
        rst = 1;
        tick();
        rst = 0;
        see("mfrst", 16'h0000, 0, 0, 0);
        chk("mfrst.state", 16'(state), 16'd0);
        tick(); see("mfr0", 16'h0000, 1, 0, 0);
        tick(); see("mfr1", 16'h0001, 1, 0, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
